// File: rtl/ddr_rd_stride_gen.sv
// Strided DDR read job engine: issues burst_num rows of burst beats as read commands of at most
// MAX_LEN beats, counts returned beats and reports completion on done.
module ddr_rd_stride_gen #(
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8,
    parameter int MAX_LEN    = 16,
    parameter int BEAT_BYTES = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DDR_ADDR_W-1:0] st_addr_i,
    input  logic [BURST_W-1:0]    burst_i,
    input  logic [DDR_ADDR_W-1:0] step_i,
    input  logic [BURST_W-1:0]    burst_num_i,
    output logic                  done_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DDR_ADDR_W-1:0] rd_addr_o,
    output logic [7:0]            rd_len_o,
    input  logic                  rd_data_valid_i,
    output logic                  err_o
);
    // Lengths need 9 bits: a command may carry up to 256 beats.
    localparam int LW = 9;
    localparam int CW = 2 * BURST_W;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  done_q, done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DDR_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]            rd_len_q, rd_len_d;
    logic                  err_q, err_d;
    logic [DDR_ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [DDR_ADDR_W-1:0] step_q, step_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic [BURST_W-1:0]    rem_row_q, rem_row_d;
    logic [BURST_W-1:0]    rows_left_q, rows_left_d;
    logic [CW-1:0]         exp_q, exp_d;
    logic [CW-1:0]         recv_q, recv_d;

    logic                  beat_cnt;
    logic [LW-1:0]         cur_len;
    logic [LW-1:0]         rem_left;

    function automatic logic [7:0] cmd_len(input logic [LW-1:0] rem);
        logic [LW-1:0] l;
        l = (rem > LW'(MAX_LEN)) ? LW'(MAX_LEN) : rem;
        return 8'(l - LW'(1));
    endfunction

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        rd_valid_d  = rd_valid_q;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        err_d       = err_q;
        row_addr_d  = row_addr_q;
        step_d      = step_q;
        burst_d     = burst_q;
        rem_row_d   = rem_row_q;
        rows_left_d = rows_left_q;
        exp_d       = exp_q;
        cur_len     = LW'(rd_len_q) + LW'(1);
        rem_left    = LW'(rem_row_q) - cur_len;

        // Beats may return while commands are still being issued, so count in CMD as well.
        beat_cnt = rd_data_valid_i && (state_q != S_IDLE) && (recv_q != exp_q);
        recv_d   = recv_q + CW'(beat_cnt);
        if (rd_data_valid_i && ((state_q == S_IDLE) || (recv_q == exp_q)))
            err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d       = 1'b0;
                    done_d      = 1'b0;
                    burst_d     = burst_i;
                    step_d      = step_i;
                    row_addr_d  = st_addr_i;
                    rd_addr_d   = st_addr_i;
                    rem_row_d   = burst_i;
                    rows_left_d = burst_num_i;
                    exp_d       = CW'(burst_i) * CW'(burst_num_i);
                    recv_d      = '0;
                    if ((burst_i == '0) || (burst_num_i == '0)) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_CMD;
                        rd_valid_d = 1'b1;
                        rd_len_d   = cmd_len(LW'(burst_i));
                    end
                end
            end
            S_CMD: begin
                if (rd_ready_i) begin
                    if (rem_left != '0) begin
                        rem_row_d = BURST_W'(rem_left);
                        rd_addr_d = rd_addr_q + DDR_ADDR_W'(cur_len) * DDR_ADDR_W'(BEAT_BYTES);
                        rd_len_d  = cmd_len(rem_left);
                    end else if (rows_left_q > BURST_W'(1)) begin
                        rows_left_d = rows_left_q - BURST_W'(1);
                        row_addr_d  = row_addr_q + step_q;
                        rd_addr_d   = row_addr_q + step_q;
                        rem_row_d   = burst_q;
                        rd_len_d    = cmd_len(LW'(burst_q));
                    end else begin
                        rd_valid_d = 1'b0;
                        if (recv_d == exp_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (recv_d == exp_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
            err_q       <= 1'b0;
            row_addr_q  <= '0;
            step_q      <= '0;
            burst_q     <= '0;
            rem_row_q   <= '0;
            rows_left_q <= '0;
            exp_q       <= '0;
            recv_q      <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            err_q       <= err_d;
            row_addr_q  <= row_addr_d;
            step_q      <= step_d;
            burst_q     <= burst_d;
            rem_row_q   <= rem_row_d;
            rows_left_q <= rows_left_d;
            exp_q       <= exp_d;
            recv_q      <= recv_d;
        end
    end

    assign done_o     = done_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_len_o   = rd_len_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ddr_rd_stride_gen.sv
// Bench for ddr_rd_stride_gen: expected command lists are derived row by row from the job
// geometry; returned beats are randomized but never exceed the beats already requested.
module tb_ddr_rd_stride_gen;
    logic        clk = 1'b0;
    logic        rst, start, rd_ready, rd_dv;
    logic [31:0] st_addr, step, rd_addr;
    logic [7:0]  burst, burst_num, rd_len;
    logic        done, rd_valid, err;
    int          nasserts = 0;
    int          nfail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } cmd_t;

    always #5 clk = ~clk;

    ddr_rd_stride_gen dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .st_addr_i(st_addr), .burst_i(burst),
        .step_i(step), .burst_num_i(burst_num), .done_o(done), .rd_valid_o(rd_valid),
        .rd_ready_i(rd_ready), .rd_addr_o(rd_addr), .rd_len_o(rd_len),
        .rd_data_valid_i(rd_dv), .err_o(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nasserts++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random ready
    task automatic run_job(input logic [31:0] sa, input logic [7:0] b, input logic [31:0] st,
                           input logic [7:0] bn, input int mode);
        cmd_t        q[$];
        cmd_t        c;
        int          total, sent, acc, cyc, chunk;
        logic        rdy, hs, beat, stall, got_cmd;
        logic [31:0] paddr;
        logic [7:0]  plen;
        total = int'(b) * int'(bn);
        for (int r = 0; r < int'(bn); r++) begin
            for (int off = 0; off < int'(b); off += 16) begin
                chunk  = (int'(b) - off > 16) ? 16 : int'(b) - off;
                c.addr = sa + 32'(r) * st + 32'(off * 32);
                c.len  = 8'(chunk - 1);
                q.push_back(c);
            end
        end
        @(negedge clk);
        st_addr = sa; burst = b; step = st; burst_num = bn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_clr", err, 0);
        check("done_fall", done, 0);
        if (total == 0) begin
            check("zero_valid", rd_valid, 0);
            burst = 8'd5; burst_num = 8'd5; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("zero_done_rise", done, 1);
            check("zero_valid2", rd_valid, 0);
            @(negedge clk);
            check("zero_start_ignored", done, 1);
            check("zero_valid3", rd_valid, 0);
            return;
        end
        check("valid_first", rd_valid, 1);
        sent = 0; acc = 0; cyc = 0; stall = 1'b0;
        forever begin
            check("done", done, (sent == total));
            if (sent == total) break;
            if (cyc > 3000) begin
                check("timeout", 1, 0);
                break;
            end
            if (stall) begin
                check("hold_addr", rd_addr, paddr);
                check("hold_len", rd_len, plen);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_ready = rdy;
            hs       = rd_valid && rdy;
            stall    = rd_valid && !rdy;
            paddr    = rd_addr;
            plen     = rd_len;
            got_cmd  = 1'b0;
            if (hs) begin
                if (q.size() == 0) begin
                    check("extra_cmd", 1, 0);
                end else begin
                    c = q.pop_front();
                    got_cmd = 1'b1;
                    check("cmd_addr", rd_addr, c.addr);
                    check("cmd_len", rd_len, c.len);
                end
            end
            beat  = (sent < acc) && ($urandom_range(0, 1) == 1);
            rd_dv = beat;
            if (beat) sent++;
            if (got_cmd) acc += int'(c.len) + 1;
            cyc++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        rd_dv    = 1'b0;
        check("cmds_left", q.size(), 0);
        check("end_valid", rd_valid, 0);
        check("end_err", err, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rd_ready = 1'b0; rd_dv = 1'b0;
        st_addr = '0; step = '0; burst = '0; burst_num = '0;
        repeat (2) @(negedge clk);
        check("rst_done", done, 1);
        check("rst_valid", rd_valid, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_len", rd_len, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", done, 1);

        run_job(32'h0000_1000, 8'd8, 32'h400, 8'd3, 0);
        run_job(32'h0, 8'd40, 32'h0, 8'd1, 0);
        run_job(32'h0, 8'd40, 32'h2000, 8'd2, 1);
        run_job(32'h0000_8000, 8'd0, 32'h100, 8'd3, 0);
        run_job(32'h0000_8000, 8'd4, 32'h100, 8'd0, 0);
        run_job(32'hFFFF_FF00, 8'd1, 32'h100, 8'd2, 0);

        // Reset in the middle of command issue, then a stray beat while idle.
        @(negedge clk);
        st_addr = 32'h3000; burst = 8'd40; step = 32'h800; burst_num = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", rd_valid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", rd_valid, 0);
        check("async_rst_done", done, 1);
        check("async_rst_err", err, 0);
        @(negedge clk);
        rst   = 1'b0;
        rd_dv = 1'b1;
        @(negedge clk);
        rd_dv = 1'b0;
        check("stray_err", err, 1);
        @(negedge clk);
        check("stray_err_sticky", err, 1);
        run_job(32'h0000_0040, 8'd3, 32'h40, 8'd2, 2);

        for (int k = 0; k < 6; k++) begin
            run_job($urandom, 8'($urandom_range(1, 40)), $urandom, 8'($urandom_range(1, 4)),
                    int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end
endmodule
